// File: rtl/key_bounce_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_bounce_gen
// Description : Button-press emulator. Emits one active-low, mechanically
//               bounced key press per accepted start: press bounce, stable
//               low hold, release bounce, then idle high with a done pulse.
//               Optional macro KEY_BOUNCE_GEN_LFSR_EN stretches each bounce
//               segment by a pseudo-random 0..7 clocks from an 8-bit LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module key_bounce_gen #(
  parameter int CNT_W      = 20,
  parameter int BOUNCE_CNT = 2,
  parameter int BOUNCE_GAP = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [CNT_W-1:0] hold_len,
  output logic             key,
  output logic             busy,
  output logic             done_pulse
);

  // Segment counter must hold up to BOUNCE_GAP+7-1 when the LFSR stretch is on.
  localparam int         C_SEG_W      = $clog2(BOUNCE_GAP + 8) + 1;
  localparam logic [4:0] C_LAST_SEG   = 5'(2 * BOUNCE_CNT - 1);
  localparam logic       C_HAS_BOUNCE = (BOUNCE_CNT > 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESS_B = 3'd1,
    HOLD    = 3'd2,
    REL_B   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               key_q, key_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   hold_len_q, hold_len_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [C_SEG_W-1:0] seg_cnt_q, seg_cnt_d;
  logic [4:0]         seg_num_q, seg_num_d;

  logic [C_SEG_W-1:0] w_seg_len;
  logic               w_seg_end;

`ifdef KEY_BOUNCE_GEN_LFSR_EN
  logic [7:0] lfsr_q;
  logic       w_lfsr_fb;

  // x^8+x^6+x^5+x^4+1 Fibonacci feedback
  assign w_lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign w_seg_len = C_SEG_W'(BOUNCE_GAP) + C_SEG_W'(lfsr_q[2:0]);

  // Advance the LFSR once at every bounce segment boundary
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lfsr_q <= 8'hA5;
    end else if (((state_q == PRESS_B) || (state_q == REL_B)) && w_seg_end) begin
      lfsr_q <= {lfsr_q[6:0], w_lfsr_fb};
    end
  end
`else
  assign w_seg_len = C_SEG_W'(BOUNCE_GAP);
`endif

  assign w_seg_end = (seg_cnt_q == (w_seg_len - C_SEG_W'(1)));

  // State and datapath registers, all cleared by synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      key_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hold_len_q <= '0;
      hold_cnt_q <= '0;
      seg_cnt_q  <= '0;
      seg_num_q  <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hold_len_q <= hold_len_d;
      hold_cnt_q <= hold_cnt_d;
      seg_cnt_q  <= seg_cnt_d;
      seg_num_q  <= seg_num_d;
    end
  end

  // Next-state and next-output logic; key value always changes on a register edge
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hold_len_d = hold_len_q;
    hold_cnt_d = hold_cnt_q;
    seg_cnt_d  = seg_cnt_q;
    seg_num_d  = seg_num_q;

    case (state_q)
      IDLE: begin
        key_d  = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          hold_len_d = (hold_len == '0) ? CNT_W'(1) : hold_len;
          busy_d     = 1'b1;
          key_d      = 1'b0;
          hold_cnt_d = '0;
          seg_cnt_d  = '0;
          seg_num_d  = '0;
          state_d    = C_HAS_BOUNCE ? PRESS_B : HOLD;
        end
      end

      PRESS_B, REL_B: begin
        if (w_seg_end) begin
          seg_cnt_d = '0;
          if (seg_num_q == C_LAST_SEG) begin
            seg_num_d = '0;
            if (state_q == PRESS_B) begin
              key_d      = 1'b0;
              hold_cnt_d = '0;
              state_d    = HOLD;
            end else begin
              key_d   = 1'b1;
              done_d  = 1'b1;
              state_d = DONE;
            end
          end else begin
            seg_num_d = seg_num_q + 5'd1;
            key_d     = ~key_q;
          end
        end else begin
          seg_cnt_d = seg_cnt_q + C_SEG_W'(1);
        end
      end

      HOLD: begin
        if (hold_cnt_q == (hold_len_q - CNT_W'(1))) begin
          key_d      = 1'b1;
          hold_cnt_d = '0;
          if (C_HAS_BOUNCE) begin
            seg_cnt_d = '0;
            seg_num_d = '0;
            state_d   = REL_B;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        key_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        key_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign key        = key_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;

endmodule
`default_nettype wire

// File: tb/tb_key_bounce_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_bounce_gen
// Description : Self-checking bench for key_bounce_gen. Expected per-cycle
//               {key,busy,done_pulse} tuples are queued when a start is
//               driven and compared cycle by cycle against two instances:
//               default bounce settings and BOUNCE_CNT=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_bounce_gen;

  localparam int BC = 2;
  localparam int G  = 3;
  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start0;
  logic [CW-1:0] hold_len, hold_len0;
  logic          key, busy, done_pulse;
  logic          key0, busy0, done0;

  int checks = 0;
  int errors = 0;

  logic [2:0] q[$];
  logic [2:0] q0[$];
  logic [7:0] m_lfsr;
  logic       rec1 = 1'b0;
  logic       rec2 = 1'b0;
  logic       tr1[$];
  logic       tr2[$];
  int         hs, rs, cyc;

  always #5 clk = ~clk;

  key_bounce_gen #(.CNT_W(CW), .BOUNCE_CNT(BC), .BOUNCE_GAP(G)) dut (
    .sys_clk(clk), .sys_rst(rst), .start(start), .hold_len(hold_len),
    .key(key), .busy(busy), .done_pulse(done_pulse)
  );

  key_bounce_gen #(.CNT_W(CW), .BOUNCE_CNT(0), .BOUNCE_GAP(G)) dut0 (
    .sys_clk(clk), .sys_rst(rst), .start(start0), .hold_len(hold_len0),
    .key(key0), .busy(busy0), .done_pulse(done0)
  );

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed key/busy/done=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Length of the next bounce segment from the reference model
  task automatic next_len(output int len);
`ifdef KEY_BOUNCE_GEN_LFSR_EN
    len    = G + int'(m_lfsr[2:0]);
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`else
    len = G;
`endif
  endtask

  // Queue the full expected waveform of one press on the default instance
  task automatic push_press(input int h, output int hold_start, output int rel_start);
    int hh;
    int len;
    int base;
    hh   = (h == 0) ? 1 : h;
    base = q.size();
    for (int s = 0; s < 2 * BC; s++) begin
      next_len(len);
      for (int c = 0; c < len; c++) q.push_back({s[0], 1'b1, 1'b0});
    end
    hold_start = q.size() - base;
    for (int c = 0; c < hh; c++) q.push_back(3'b010);
    rel_start = q.size() - base;
    for (int s = 0; s < 2 * BC; s++) begin
      next_len(len);
      for (int c = 0; c < len; c++) q.push_back({~s[0], 1'b1, 1'b0});
    end
    q.push_back(3'b111);
  endtask

  // Queue the expected waveform of one press on the no-bounce instance
  task automatic push0(input int h);
    int hh;
    hh = (h == 0) ? 1 : h;
    for (int c = 0; c < hh; c++) q0.push_back(3'b010);
    q0.push_back(3'b111);
  endtask

  // Advance one clock and compare both instances against their queues
  task automatic tick();
    logic [2:0] e;
    logic [2:0] e0;
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() > 0) e = q.pop_front(); else e = 3'b100;
    if (q0.size() > 0) e0 = q0.pop_front(); else e0 = 3'b100;
    if (rec1) tr1.push_back(key);
    if (rec2) tr2.push_back(key);
    check($sformatf("main_c%0d", cyc), {key, busy, done_pulse}, e);
    check($sformatf("nobounce_c%0d", cyc), {key0, busy0, done0}, e0);
  endtask

  initial begin
    cyc       = 0;
    rst       = 1'b1;
    start     = 1'b0;
    start0    = 1'b0;
    hold_len  = '0;
    hold_len0 = '0;
    m_lfsr    = 8'hA5;

    // Reset held with start toggling: outputs stay idle
    for (int i = 0; i < 5; i++) begin
      start    = ~start;
      start0   = ~start0;
      hold_len = CW'(i + 3);
      tick();
    end
    rst    = 1'b0;
    start  = 1'b0;
    start0 = 1'b0;
    tick();
    tick();

    // Default press, hold_len=10; trace kept for repeatability comparison
    rec1     = 1'b1;
    hold_len = 10;
    start    = 1'b1;
    push_press(10, hs, rs);
    tick();
    start = 1'b0;
    while (q.size() > 0) tick();
    rec1 = 1'b0;
    tick();

    // start re-pulsed in HOLD with new hold_len, then in DONE: both ignored
    start = 1'b1;
    push_press(10, hs, rs);
    tick();
    start = 1'b0;
    for (int i = 1; i < hs + 3; i++) tick();
    start    = 1'b1;
    hold_len = 50;
    tick();
    start = 1'b0;
    while (q.size() > 0) tick();
    start = 1'b1;
    tick();
    // start held into the following IDLE cycle is accepted with hold_len=50
    push_press(50, hs, rs);
    tick();
    start = 1'b0;
    while (q.size() > 0) tick();
    tick();

    // Reset during release bounce, then a full press from a fresh reset
    hold_len = 10;
    start    = 1'b1;
    push_press(10, hs, rs);
    tick();
    start = 1'b0;
    for (int i = 1; i < rs + 3; i++) tick();
    rst = 1'b1;
    q.delete();
    m_lfsr = 8'hA5;
    tick();
    rst = 1'b0;
    tick();
    rec2  = 1'b1;
    start = 1'b1;
    push_press(10, hs, rs);
    tick();
    start = 1'b0;
    while (q.size() > 0) tick();
    rec2 = 1'b0;
    tick();

    // Press after reset must reproduce the first press after reset exactly
    checks++;
    assert (tr1.size() === tr2.size()) else begin
      errors++;
      $error("FAIL trace_len: observed=%0d expected=%0d", tr2.size(), tr1.size());
    end
    for (int i = 0; i < tr1.size() && i < tr2.size(); i++)
      check($sformatf("trace_%0d", i), {2'b00, tr2[i]}, {2'b00, tr1[i]});

    // No-bounce instance: hold_len=0 behaves as 1, then hold_len=4
    hold_len0 = 0;
    start0    = 1'b1;
    push0(0);
    tick();
    start0 = 1'b0;
    while (q0.size() > 0) tick();
    tick();
    hold_len0 = 4;
    start0    = 1'b1;
    push0(4);
    tick();
    start0 = 1'b0;
    while (q0.size() > 0) tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
